// File: rtl/mfhwt_pp_packer.sv
// Ping-pong word packer: gathers NWORDS words into a line using two banks,
// and offers each closed line to the downstream stage with a ready/ack handshake.
module mfhwt_pp_packer #(
  parameter int DATA_W = 16,
  parameter int NWORDS = 4,
  parameter int CNT_W  = $clog2(NWORDS + 1)
) (
  input  logic                     iClk,
  input  logic                     iReset_n,
  input  logic                     iWrreq,
  input  logic [DATA_W-1:0]        iData,
  input  logic                     iFlush,
  output logic                     oFull,
  output logic                     oRdready,
  input  logic                     iRdack,
  output logic [DATA_W*NWORDS-1:0] oData,
  output logic [CNT_W-1:0]         oCount,
  output logic                     oBank,
  output logic                     oOverflow
);

  localparam int LINE_W = DATA_W * NWORDS;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  bank_state_e       state_q [2];
  bank_state_e       state_d [2];
  logic [LINE_W-1:0] line_q  [2];
  logic [LINE_W-1:0] line_d  [2];
  logic [CNT_W-1:0]  cnt_q   [2];
  logic [CNT_W-1:0]  cnt_d   [2];
  logic              wb_q, wb_d;
  logic              rb_q, rb_d;
  logic              overflow_q, overflow_d;

  logic              wr_full;
  logic              rd_ready;
  logic              wr_acc;
  logic              rd_acc;
  logic              line_close;
  logic [CNT_W-1:0]  cnt_inc;

  // Full/ready come from registered state only, so an ack cannot unblock a write in the same cycle.
  assign wr_full  = (state_q[wb_q] == BANK_FULL);
  assign rd_ready = (state_q[rb_q] == BANK_FULL);
  assign wr_acc   = iWrreq && !wr_full;
  assign rd_acc   = iRdack && rd_ready;
  assign cnt_inc  = cnt_q[wb_q] + CNT_W'(wr_acc);
  assign line_close = !wr_full &&
                      ((cnt_inc == CNT_W'(NWORDS)) || (iFlush && (cnt_inc != '0)));

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    cnt_d      = cnt_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    overflow_d = overflow_q;

    // An accepted ack always targets a FULL bank, and a write never lands in a FULL bank,
    // so the two updates below never touch the same bank in one cycle.
    if (rd_acc) begin
      state_d[rb_q] = BANK_EMPTY;
      line_d[rb_q]  = '0;
      cnt_d[rb_q]   = '0;
      rb_d          = ~rb_q;
    end

    if (wr_acc) begin
      for (int s = 0; s < NWORDS; s++) begin
        if (cnt_q[wb_q] == CNT_W'(s)) begin
          line_d[wb_q][s*DATA_W +: DATA_W] = iData;
        end
      end
      cnt_d[wb_q]   = cnt_inc;
      state_d[wb_q] = BANK_FILLING;
    end

    if (line_close) begin
      state_d[wb_q] = BANK_FULL;
      wb_d          = ~wb_q;
    end

    if (iWrreq && wr_full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q    <= '{default: BANK_EMPTY};
      line_q     <= '{default: '0};
      cnt_q      <= '{default: '0};
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      overflow_q <= overflow_d;
    end
  end

  // The read bank may be the one currently filling, so data/count are only shown once it is FULL.
  assign oFull     = wr_full;
  assign oRdready  = rd_ready;
  assign oData     = rd_ready ? line_q[rb_q] : '0;
  assign oCount    = rd_ready ? cnt_q[rb_q] : '0;
  assign oBank     = rb_q;
  assign oOverflow = overflow_q;

endmodule

// File: tb/tb_mfhwt_pp_packer.sv
// Directed bench for mfhwt_pp_packer: hand-computed lines, flush, backpressure,
// overflow, mid-line reset and no-op events.
module tb_mfhwt_pp_packer;

  logic        iClk = 1'b0;
  logic        iReset_n;
  logic        iWrreq;
  logic [15:0] iData;
  logic        iFlush;
  logic        oFull;
  logic        oRdready;
  logic        iRdack;
  logic [63:0] oData;
  logic [2:0]  oCount;
  logic        oBank;
  logic        oOverflow;

  int n_cmp = 0;
  int n_err = 0;

  mfhwt_pp_packer #(.DATA_W(16), .NWORDS(4)) dut (
    .iClk      (iClk),
    .iReset_n  (iReset_n),
    .iWrreq    (iWrreq),
    .iData     (iData),
    .iFlush    (iFlush),
    .oFull     (oFull),
    .oRdready  (oRdready),
    .iRdack    (iRdack),
    .oData     (oData),
    .oCount    (oCount),
    .oBank     (oBank),
    .oOverflow (oOverflow)
  );

  always #5 iClk = ~iClk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic idle();
    iWrreq = 1'b0;
    iData  = '0;
    iFlush = 1'b0;
    iRdack = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    iReset_n = 1'b0;
    tick();
    iReset_n = 1'b1;
  endtask

  task automatic wr(input logic [15:0] d, input logic flush);
    iWrreq = 1'b1;
    iData  = d;
    iFlush = flush;
    tick();
    idle();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_full"},  64'(oFull),     64'd0);
    check_eq({tag, "_rdy"},   64'(oRdready),  64'd0);
    check_eq({tag, "_cnt"},   64'(oCount),    64'd0);
    check_eq({tag, "_data"},  oData,          64'd0);
    check_eq({tag, "_ovf"},   64'(oOverflow), 64'd0);
    check_eq({tag, "_bank"},  64'(oBank),     64'd0);
  endtask

  initial begin
    iReset_n = 1'b0;
    idle();

    // 1: reset state then one full line
    do_reset();
    check_all_zero("t1_rst");
    wr(16'h1111, 1'b0);
    wr(16'h2222, 1'b0);
    wr(16'h3333, 1'b0);
    check_eq("t1_rdy_pre", 64'(oRdready), 64'd0);
    wr(16'h4444, 1'b0);
    check_eq("t1_rdy",  64'(oRdready), 64'd1);
    check_eq("t1_data", oData, 64'h4444_3333_2222_1111);
    check_eq("t1_cnt",  64'(oCount), 64'd4);
    check_eq("t1_bank", 64'(oBank), 64'd0);
    iRdack = 1'b1;
    tick();
    idle();
    check_eq("t1_ack_rdy",  64'(oRdready), 64'd0);
    check_eq("t1_ack_bank", 64'(oBank), 64'd1);

    // 2: 8 back-to-back writes with ack held high
    do_reset();
    for (int i = 0; i < 8; i++) begin
      iWrreq = 1'b1;
      iData  = 16'(16'hA0 + i);
      iRdack = 1'b1;
      tick();
      check_eq($sformatf("t2_full_%0d", i), 64'(oFull), 64'd0);
      if (i == 3) begin
        check_eq("t2_l0_rdy",  64'(oRdready), 64'd1);
        check_eq("t2_l0_bank", 64'(oBank), 64'd0);
        check_eq("t2_l0_data", oData, 64'h00A3_00A2_00A1_00A0);
      end
      if (i == 7) begin
        check_eq("t2_l1_rdy",  64'(oRdready), 64'd1);
        check_eq("t2_l1_bank", 64'(oBank), 64'd1);
        check_eq("t2_l1_data", oData, 64'h00A7_00A6_00A5_00A4);
      end
    end
    iWrreq = 1'b0;
    tick();
    idle();
    check_eq("t2_drain_rdy", 64'(oRdready), 64'd0);
    check_eq("t2_ovf",       64'(oOverflow), 64'd0);

    // 3: flush of partial lines
    do_reset();
    wr(16'hAAAA, 1'b0);
    wr(16'hBBBB, 1'b0);
    iFlush = 1'b1;
    tick();
    idle();
    check_eq("t3_f_rdy",  64'(oRdready), 64'd1);
    check_eq("t3_f_data", oData, 64'h0000_0000_BBBB_AAAA);
    check_eq("t3_f_cnt",  64'(oCount), 64'd2);
    iRdack = 1'b1;
    tick();
    idle();
    wr(16'h0001, 1'b0);
    wr(16'h0002, 1'b0);
    wr(16'h0003, 1'b1);
    check_eq("t3_wf_rdy",  64'(oRdready), 64'd1);
    check_eq("t3_wf_cnt",  64'(oCount), 64'd3);
    check_eq("t3_wf_data", oData, 64'h0000_0003_0002_0001);
    check_eq("t3_wf_bank", 64'(oBank), 64'd1);

    // 4: backpressure, drops and overflow; a write in the ack cycle is still dropped
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      wr(16'(i), 1'b0);
      if (i == 8) begin
        check_eq("t4_full8", 64'(oFull), 64'd1);
        check_eq("t4_ovf8",  64'(oOverflow), 64'd0);
      end
    end
    check_eq("t4_ovf",  64'(oOverflow), 64'd1);
    check_eq("t4_data", oData, 64'h0004_0003_0002_0001);
    check_eq("t4_bank", 64'(oBank), 64'd0);
    iRdack = 1'b1;
    iWrreq = 1'b1;
    iData  = 16'hDEAD;
    tick();
    idle();
    check_eq("t4_ack_bank", 64'(oBank), 64'd1);
    check_eq("t4_ack_full", 64'(oFull), 64'd0);
    check_eq("t4_ack_data", oData, 64'h0008_0007_0006_0005);
    iRdack = 1'b1;
    tick();
    idle();
    check_eq("t4_ack2_rdy", 64'(oRdready), 64'd0);
    wr(16'h0001, 1'b1);
    check_eq("t4_nodead_cnt",  64'(oCount), 64'd1);
    check_eq("t4_nodead_data", oData, 64'h0000_0000_0000_0001);
    check_eq("t4_ovf_sticky",  64'(oOverflow), 64'd1);

    // 5: reset mid-line with bank 0 FULL
    do_reset();
    for (int i = 0; i < 7; i++) wr(16'(16'h10 + i), 1'b0);
    check_eq("t5_pre_rdy", 64'(oRdready), 64'd1);
    do_reset();
    check_all_zero("t5_rst");
    wr(16'h5001, 1'b0);
    wr(16'h5002, 1'b0);
    wr(16'h5003, 1'b0);
    wr(16'h5004, 1'b0);
    check_eq("t5_bank", 64'(oBank), 64'd0);
    check_eq("t5_data", oData, 64'h5004_5003_5002_5001);
    check_eq("t5_cnt",  64'(oCount), 64'd4);

    // 6: flush on empty bank and stray ack are no-ops
    do_reset();
    iFlush = 1'b1;
    tick();
    idle();
    check_eq("t6_flush_rdy",  64'(oRdready), 64'd0);
    check_eq("t6_flush_bank", 64'(oBank), 64'd0);
    iRdack = 1'b1;
    tick();
    idle();
    check_eq("t6_ack_rdy",  64'(oRdready), 64'd0);
    check_eq("t6_ack_bank", 64'(oBank), 64'd0);
    wr(16'h6001, 1'b0);
    wr(16'h6002, 1'b0);
    wr(16'h6003, 1'b0);
    wr(16'h6004, 1'b0);
    check_eq("t6_line_cnt",  64'(oCount), 64'd4);
    check_eq("t6_line_data", oData, 64'h6004_6003_6002_6001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
